ring_rr_arbiter: RTL and testbench
==================================

# ring_rr_arbiter

Round-robin arbiter that shares one resource among N requesters using a one-hot rotating priority token, the same rotation a ring counter performs. The token advances one position past each owner when that owner releases, so every requester gets a turn. A per-grant hold limit forces rotation when an owner does not release. The block sits between the requesting datapath units and the shared resource, driving a one-hot grant and an encoded owner id.

## Interface

- N, 4: number of requesters, at least 2.
- MAX_HOLD, 8: maximum consecutive cycles a grant may be held, at least 2.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  when high, new grants may be issued. When low, no new grant starts; a grant already in progress is unaffected.
- req  input  N  request bits; bit i belongs to requester i; level-sensitive.
- done  input  N  release pulse; only bit [owner] is honoured, all other bits are ignored.
- grant  output  N  one-hot grant, or all zeros.
- grant_valid  output  1  OR of grant, registered.
- grant_id  output  clog2(N)  index of the current owner; holds its last value while idle.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation

- State machine with two states, IDLE and BUSY.
- Token `ptr` is an N-bit one-hot register. It marks the highest-priority requester.
- Search rule: the winner is the first i with req[i]=1, scanning from ptr's index upward. Index N-1 wraps to 0.
- IDLE:
  - If en=1 and req is nonzero, go to BUSY on the next edge.
  - Registered on that edge: grant = one-hot(winner), grant_id = winner, hold_cnt = 1.
  - ptr is unchanged.
- BUSY, release condition: done[owner]=1 or req[owner]=0. On that edge:
  - Go to IDLE and set grant = 0.
  - Rotate ptr to one-hot(owner+1 mod N).
  - timeout stays 0.
- BUSY, timeout condition: no release and hold_cnt == MAX_HOLD. On that edge:
  - Same actions as a release (IDLE, grant = 0, ptr rotated to owner+1).
  - timeout = 1 for exactly one cycle.
- BUSY, otherwise: hold_cnt increments and grant is held.
- If release and timeout hit on the same edge, release wins and timeout is not pulsed.
- Requests from non-owners during BUSY have no effect; preemption never occurs.
- A requester that drops req before it is granted loses nothing. The search always uses the current req.
- hold_cnt width is clog2(MAX_HOLD+1) bits, saturating logic is not needed, and it never exceeds MAX_HOLD.
- Invariant: grant is either zero or one-hot, and ptr is always one-hot.

## Timing

- Reset (asynchronous on rst_n low):
  - state = IDLE, ptr = 1 (requester 0 has top priority).
  - grant = 0, grant_valid = 0, grant_id = 0, timeout = 0, hold_cnt = 0.
- Grant latency: req sampled high at edge k while IDLE (with en=1) gives grant high after edge k.
- Maximum grant length: MAX_HOLD cycles.
- Minimum idle gap: after any release or timeout, grant is 0 for at least one full cycle. The next grant appears after the following edge at the earliest.
- Back-to-back turnaround when all requesters keep requesting: MAX_HOLD grant cycles plus 1 gap cycle per owner.
- Reset in mid-grant: grant drops immediately (asynchronously) and ptr returns to 1.
- en falling during BUSY has no effect on the current grant. en low in IDLE holds the block in IDLE.

## Test plan

- Reset: hold rst_n=0 with req=4'b1111 -> grant=0, grant_valid=0, grant_id=0, timeout=0. After rst_n rises, the first grant is 4'b0001 one cycle later.
- Round-robin: req=4'b1111, each owner pulses done on its 2nd grant cycle -> grant sequence 0001, 0010, 0100, 1000, 0001 with one zero cycle between each grant.
- Timeout: req=4'b0100 held, done never asserted, MAX_HOLD=8 -> grant=0100 for exactly 8 cycles, timeout=1 for one cycle, ptr=1000. The next grant is 0100 again after a 1-cycle gap.
- Wrap and skip: ptr at index 3 with req=4'b0101 -> grant 0001. After release, grant 0100.
- Simultaneous events: done[owner]=1 on the edge where hold_cnt==MAX_HOLD -> release with timeout=0. done on a non-owner bit -> ignored, grant unchanged.
- Reset mid-grant and en gating: rst_n low during BUSY -> grant=0 immediately. en=0 with req=4'b0010 -> no grant; en rising -> grant=0010 after the next edge.

Source files
------------

// File: rtl/ring_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// ring_rr_arbiter_if : request/grant bundle between requesters and arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ring_rr_arbiter_if #(
  parameter int N = 4
);
  localparam int ID_W = $clog2(N);

  logic            en;
  logic [N-1:0]    req;
  logic [N-1:0]    done;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic            timeout;

  modport master (
    output en, req, done,
    input  grant, grant_valid, grant_id, timeout
  );

  modport slave (
    input  en, req, done,
    output grant, grant_valid, grant_id, timeout
  );
endinterface

`default_nettype wire

// File: rtl/ring_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ring_rr_arbiter : one-hot token round-robin arbiter with per-grant hold limit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  ring_rr_arbiter_if.slave  arb
);

  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_ptr;
  logic [N-1:0]     r_grant;
  logic             r_grant_valid;
  logic [ID_W-1:0]  r_grant_id;
  logic             r_timeout;
  logic [CNT_W-1:0] r_hold;

  logic [ID_W-1:0]  w_ptr_idx;
  logic [ID_W-1:0]  w_winner;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic [N-1:0]     w_win_onehot;
  logic [N-1:0]     w_ptr_next;
  logic             w_release;
  logic             w_hold_max;

  always_comb begin
    w_ptr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_ptr[i]) w_ptr_idx = ID_W'(i);
    end
  end

  // Scan from the highest offset down so the closest requester to ptr wins last.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(w_ptr_idx) + k) % N);
      if (arb.req[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_winner;
  // Grant is one-hot in BUSY, so rotating it yields one-hot(owner+1 mod N).
  assign w_ptr_next   = {r_grant[N-2:0], r_grant[N-1]};
  assign w_release    = ((arb.done & r_grant) != '0) || ((arb.req & r_grant) == '0);
  assign w_hold_max   = (r_hold == CNT_W'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= {{(N-1){1'b0}}, 1'b1};
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_timeout     <= 1'b0;
      r_hold        <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (arb.en && w_any) begin
            r_state       <= S_BUSY;
            r_grant       <= w_win_onehot;
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_winner;
            r_hold        <= CNT_W'(1);
          end
        end
        S_BUSY: begin
          if (w_release || w_hold_max) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_ptr         <= w_ptr_next;
            r_hold        <= '0;
            r_timeout     <= !w_release;
          end else begin
            r_hold <= r_hold + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign arb.grant       = r_grant;
  assign arb.grant_valid = r_grant_valid;
  assign arb.grant_id    = r_grant_id;
  assign arb.timeout     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_ring_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ring_rr_arbiter : directed self-checking bench for ring_rr_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ring_rr_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ring_rr_arbiter_if #(.N(4)) arb ();

  ring_rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    arb.en    = 1'b1;
    arb.req   = 4'b1111;
    arb.done  = 4'b0000;

    // Reset held with all requesting
    step();
    step();
    chk("rst_grant", 32'(arb.grant), 32'h0);
    chk("rst_valid", 32'(arb.grant_valid), 32'h0);
    chk("rst_id", 32'(arb.grant_id), 32'h0);
    chk("rst_timeout", 32'(arb.timeout), 32'h0);
    rst_n = 1'b1;
    step();
    chk("first_grant", 32'(arb.grant), 32'h1);
    chk("first_valid", 32'(arb.grant_valid), 32'h1);

    // Round robin, each owner releases on its second grant cycle
    for (int o = 0; o < 4; o++) begin
      step();
      chk("rr_hold", 32'(arb.grant), 32'(1) << o);
      arb.done = 4'(1 << o);
      step();
      arb.done = 4'b0000;
      chk("rr_gap", 32'(arb.grant), 32'h0);
      chk("rr_gap_to", 32'(arb.timeout), 32'h0);
      step();
      chk("rr_next", 32'(arb.grant), 32'(1) << ((o + 1) % 4));
      chk("rr_next_id", 32'(arb.grant_id), 32'((o + 1) % 4));
    end

    // Timeout: requester 2 never releases
    arb.done = 4'b0001;
    arb.req  = 4'b0100;
    step();
    arb.done = 4'b0000;
    chk("to_gap0", 32'(arb.grant), 32'h0);
    step();
    chk("to_grant1", 32'(arb.grant), 32'h4);
    for (int k = 2; k <= 8; k++) begin
      step();
      chk("to_grant_n", 32'(arb.grant), 32'h4);
      chk("to_no_pulse", 32'(arb.timeout), 32'h0);
    end
    step();
    chk("to_revoke", 32'(arb.grant), 32'h0);
    chk("to_pulse", 32'(arb.timeout), 32'h1);
    chk("to_ptr", 32'(dut.r_ptr), 32'h8);
    step();
    chk("to_regrant", 32'(arb.grant), 32'h4);
    chk("to_pulse_end", 32'(arb.timeout), 32'h0);

    // Wrap and skip from ptr index 3
    arb.done = 4'b0100;
    arb.req  = 4'b0101;
    step();
    arb.done = 4'b0000;
    chk("wrap_gap", 32'(arb.grant), 32'h0);
    step();
    chk("wrap_grant", 32'(arb.grant), 32'h1);
    chk("wrap_id", 32'(arb.grant_id), 32'h0);
    arb.done = 4'b0001;
    step();
    arb.done = 4'b0000;
    chk("skip_gap", 32'(arb.grant), 32'h0);
    step();
    chk("skip_grant", 32'(arb.grant), 32'h4);
    chk("skip_id", 32'(arb.grant_id), 32'h2);

    // Non-owner done ignored, then done coincident with hold limit
    for (int k = 0; k < 7; k++) begin
      arb.done = (k == 3) ? 4'b1011 : 4'b0000;
      step();
      chk("sim_hold", 32'(arb.grant), 32'h4);
    end
    arb.done = 4'b0100;
    step();
    arb.done = 4'b0000;
    chk("sim_release", 32'(arb.grant), 32'h0);
    chk("sim_no_to", 32'(arb.timeout), 32'h0);

    // Reset mid-grant
    step();
    chk("mid_grant", 32'(arb.grant), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(arb.grant), 32'h0);
    chk("mid_rst_valid", 32'(arb.grant_valid), 32'h0);
    step();

    // en gating in IDLE and during BUSY
    arb.en  = 1'b0;
    arb.req = 4'b0010;
    rst_n   = 1'b1;
    step();
    chk("en_low0", 32'(arb.grant), 32'h0);
    step();
    chk("en_low1", 32'(arb.grant), 32'h0);
    arb.en = 1'b1;
    step();
    chk("en_rise", 32'(arb.grant), 32'h2);
    chk("en_rise_id", 32'(arb.grant_id), 32'h1);
    arb.en = 1'b0;
    step();
    chk("en_fall_busy", 32'(arb.grant), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
